// File: rtl/edit_mem_rsp.sv
// Edit-memory read responder: queues chunk read requests, arbitrates the SRAM
// against PD writes (writes win), and returns acks in request order.
`ifndef PORT_ID_NBITS
`define PORT_ID_NBITS 4
`endif
`ifndef DATA_PATH_NBITS
`define DATA_PATH_NBITS 128
`endif
`ifndef ENQ_ED_CMD_PD_BP_NBITS
`define ENQ_ED_CMD_PD_BP_NBITS 8
`endif
`ifndef PD_CHUNK_DEPTH_NBITS
`define PD_CHUNK_DEPTH_NBITS 6
`endif
`ifndef DATA_PATH_VB_NBITS
`define DATA_PATH_VB_NBITS 4
`endif

module edit_mem_rsp #(
    parameter int ID_NBITS       = `PORT_ID_NBITS,
    parameter int DATA_NBITS     = `DATA_PATH_NBITS,
    parameter int ADDR_NBITS     = `ENQ_ED_CMD_PD_BP_NBITS + `PD_CHUNK_DEPTH_NBITS - `DATA_PATH_VB_NBITS,
    parameter int RQ_DEPTH_NBITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    edit_mem_req,
    input  logic [ADDR_NBITS-1:0]   edit_mem_raddr,
    input  logic [ID_NBITS-1:0]     edit_mem_port_id,
    input  logic                    edit_mem_eop,
    input  logic                    pd_wr,
    input  logic [ADDR_NBITS-1:0]   pd_waddr,
    input  logic [DATA_NBITS-1:0]   pd_wdata,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [ADDR_NBITS-1:0]   mem_addr,
    output logic [DATA_NBITS-1:0]   mem_wdata,
    input  logic [DATA_NBITS-1:0]   mem_rdata,
    output logic                    edit_mem_ack,
    output logic [DATA_NBITS-1:0]   edit_mem_rdata,
    output logic                    pd_free_valid,
    output logic [ID_NBITS-1:0]     pd_free_port_id,
    output logic [RQ_DEPTH_NBITS:0] rq_count,
    output logic                    err_overflow
);

    localparam int unsigned RQ_DEPTH = 1 << RQ_DEPTH_NBITS;

    typedef struct packed {
        logic [ADDR_NBITS-1:0] addr;
        logic [ID_NBITS-1:0]   id;
        logic                  eop;
    } rq_t;

    rq_t                     rq_mem [RQ_DEPTH];
    rq_t                     head;
    logic [RQ_DEPTH_NBITS-1:0] wr_ptr;
    logic [RQ_DEPTH_NBITS-1:0] rd_ptr;
    logic                    rq_empty;
    logic                    rq_full;
    logic                    push;
    logic                    pop;
    logic                    s1_valid;
    logic                    s1_eop;
    logic [ID_NBITS-1:0]     s1_id;

    // Full is the MSB of the occupancy count (count == depth).
    always_comb begin
        head      = rq_mem[rd_ptr];
        rq_empty  = (rq_count == '0);
        rq_full   = rq_count[RQ_DEPTH_NBITS];
        pop       = !rst && !pd_wr && !rq_empty;
        push      = !rst && edit_mem_req && (!rq_full || pop);
        mem_cs    = !rst && (pd_wr || !rq_empty);
        mem_we    = !rst && pd_wr;
        mem_addr  = pd_wr ? pd_waddr : head.addr;
        mem_wdata = pd_wdata;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rq_mem[wr_ptr] <= '{addr: edit_mem_raddr, id: edit_mem_port_id, eop: edit_mem_eop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rq_count      <= '0;
            s1_valid      <= 1'b0;
            edit_mem_ack  <= 1'b0;
            pd_free_valid <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   rq_count <= rq_count + 1'b1;
                2'b01:   rq_count <= rq_count - 1'b1;
                default: rq_count <= rq_count;
            endcase
            s1_valid      <= pop;
            edit_mem_ack  <= s1_valid;
            pd_free_valid <= s1_valid && s1_eop;
            err_overflow  <= err_overflow || (edit_mem_req && rq_full && !pop);
        end
    end

    // Sideband rides with the pop; SRAM data lands one cycle later alongside it.
    always_ff @(posedge clk) begin
        if (pop) begin
            s1_id  <= head.id;
            s1_eop <= head.eop;
        end
        if (s1_valid) begin
            edit_mem_rdata  <= mem_rdata;
            pd_free_port_id <= s1_id;
        end
    end

endmodule

// File: tb/tb_edit_mem_rsp.sv
// Directed bench for edit_mem_rsp with a behavioural 1-cycle-latency SRAM.
module tb_edit_mem_rsp;

    localparam int ID_W   = 4;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              edit_mem_req;
    logic [ADDR_W-1:0] edit_mem_raddr;
    logic [ID_W-1:0]   edit_mem_port_id;
    logic              edit_mem_eop;
    logic              pd_wr;
    logic [ADDR_W-1:0] pd_waddr;
    logic [DATA_W-1:0] pd_wdata;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              edit_mem_ack;
    logic [DATA_W-1:0] edit_mem_rdata;
    logic              pd_free_valid;
    logic [ID_W-1:0]   pd_free_port_id;
    logic [3:0]        rq_count;
    logic              err_overflow;

    always #5 clk = ~clk;

    edit_mem_rsp #(
        .ID_NBITS(ID_W),
        .DATA_NBITS(DATA_W),
        .ADDR_NBITS(ADDR_W),
        .RQ_DEPTH_NBITS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .edit_mem_req(edit_mem_req), .edit_mem_raddr(edit_mem_raddr),
        .edit_mem_port_id(edit_mem_port_id), .edit_mem_eop(edit_mem_eop),
        .pd_wr(pd_wr), .pd_waddr(pd_waddr), .pd_wdata(pd_wdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .edit_mem_ack(edit_mem_ack), .edit_mem_rdata(edit_mem_rdata),
        .pd_free_valid(pd_free_valid), .pd_free_port_id(pd_free_port_id),
        .rq_count(rq_count), .err_overflow(err_overflow)
    );

    logic [DATA_W-1:0] sram [1024];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              free;
    } ack_t;

    ack_t              ack_q[$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                max_cnt;
    logic              cs_log   [1024];
    logic              we_log   [1024];
    logic [ADDR_W-1:0] addr_log [1024];
    logic [3:0]        cnt_log  [1024];

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe this cycle at the falling edge, then advance to just past the next rising edge.
    task automatic tick();
        ack_t a;
        @(negedge clk);
        if (cyc < 1024) begin
            cs_log[cyc]   = mem_cs;
            we_log[cyc]   = mem_we;
            addr_log[cyc] = mem_addr;
            cnt_log[cyc]  = rq_count;
        end
        if (int'(rq_count) > max_cnt) max_cnt = int'(rq_count);
        if (edit_mem_ack) begin
            a.cyc  = cyc;
            a.data = edit_mem_rdata;
            a.id   = pd_free_port_id;
            a.free = pd_free_valid;
            ack_q.push_back(a);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_ack(input string tag, input int idx, input int ecyc,
                             input logic [DATA_W-1:0] edata, input int eid, input logic efree);
        if (idx >= ack_q.size()) begin
            check($sformatf("%s_present", tag), 0, 1);
        end else begin
            check($sformatf("%s_cyc", tag),  ack_q[idx].cyc,  ecyc);
            check($sformatf("%s_data", tag), ack_q[idx].data, edata);
            check($sformatf("%s_id", tag),   ack_q[idx].id,   eid);
            check($sformatf("%s_free", tag), ack_q[idx].free, efree);
        end
    endtask

    task automatic set_req(input logic r, input int addr, input int id, input logic eop);
        edit_mem_req     = r;
        edit_mem_raddr   = ADDR_W'(addr);
        edit_mem_port_id = ID_W'(id);
        edit_mem_eop     = eop;
    endtask

    task automatic set_wr(input logic w, input int addr, input logic [DATA_W-1:0] data);
        pd_wr    = w;
        pd_waddr = ADDR_W'(addr);
        pd_wdata = data;
    endtask

    function automatic logic [DATA_W-1:0] pat(input int a);
        logic [7:0] b;
        b = 8'hA0 | 8'(a);
        return {16{b}};
    endfunction

    initial begin
        int t;
        logic [DATA_W-1:0] x;
        x = {8{16'hBEEF}};

        rst = 1'b1;
        set_req(1'b0, 0, 0, 1'b0);
        set_wr(1'b0, 0, '0);
        @(posedge clk);
        #1;

        // Reset: a write request while in reset must not select the SRAM.
        set_wr(1'b1, 3, '1);
        tick();
        tick();
        check("rst_cs", cs_log[cyc-1], 1'b0);
        rst = 1'b0;
        set_wr(1'b0, 0, '0);
        check("rst_count", rq_count, 0);
        check("rst_ack", edit_mem_ack, 0);
        check("rst_free", pd_free_valid, 0);
        check("rst_err", err_overflow, 0);

        // Preload addresses 0..7 through the write port.
        t = cyc;
        for (int a = 0; a < 8; a++) begin
            set_wr(1'b1, a, pat(a));
            tick();
        end
        set_wr(1'b0, 0, '0);
        check("wr_cs", cs_log[t], 1'b1);
        check("wr_we", we_log[t], 1'b1);

        // Idle: nothing selected, nothing acknowledged.
        ack_q.delete();
        t = cyc;
        repeat (4) tick();
        check("idle_cs", cs_log[t], 1'b0);
        check("idle_noack", ack_q.size(), 0);

        // Single read.
        ack_q.delete();
        t = cyc;
        set_req(1'b1, 5, 2, 1'b1);
        tick();
        set_req(1'b0, 0, 0, 1'b0);
        repeat (5) tick();
        check("single_cs", cs_log[t+1], 1'b1);
        check("single_we", we_log[t+1], 1'b0);
        check("single_addr", addr_log[t+1], 5);
        check("single_nack", ack_q.size(), 1);
        check_ack("single", 0, t+3, pat(5), 2, 1'b1);

        // Streaming: 8 back-to-back requests.
        ack_q.delete();
        max_cnt = 0;
        t = cyc;
        for (int i = 0; i < 8; i++) begin
            set_req(1'b1, i, i, i == 7);
            tick();
        end
        set_req(1'b0, 0, 0, 1'b0);
        repeat (6) tick();
        check("stream_nack", ack_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_ack($sformatf("stream%0d", i), i, t+3+i, pat(i), i, i == 7);
        check("stream_maxcnt", max_cnt, 1);

        // Write priority; also read-after-write visibility and write-after-pop invisibility.
        ack_q.delete();
        max_cnt = 0;
        t = cyc;
        set_req(1'b1, 3, 3, 1'b0);
        tick();
        set_req(1'b1, 4, 4, 1'b1);
        set_wr(1'b1, 4, x);
        tick();
        set_req(1'b0, 0, 0, 1'b0);
        tick();
        tick();
        set_wr(1'b0, 0, '0);
        tick();
        tick();
        set_wr(1'b1, 4, pat(4));
        tick();
        set_wr(1'b0, 0, '0);
        repeat (3) tick();
        check("prio_we_t3", we_log[t+3], 1'b1);
        check("prio_pop1_cs", cs_log[t+4], 1'b1);
        check("prio_pop1_we", we_log[t+4], 1'b0);
        check("prio_pop1_addr", addr_log[t+4], 3);
        check("prio_pop2_we", we_log[t+5], 1'b0);
        check("prio_pop2_addr", addr_log[t+5], 4);
        check("prio_nack", ack_q.size(), 2);
        check_ack("prio0", 0, t+6, pat(3), 3, 1'b0);
        check_ack("prio1", 1, t+7, x, 4, 1'b1);
        check("prio_maxcnt", max_cnt, 2);

        // Overflow: writes hold off reads while 9 requests arrive.
        ack_q.delete();
        t = cyc;
        for (int i = 0; i < 10; i++) begin
            set_wr(1'b1, 200, '0);
            set_req(i < 9, i % 8, i, 1'b0);
            tick();
        end
        set_wr(1'b0, 0, '0);
        set_req(1'b0, 0, 0, 1'b0);
        check("ovf_full", cnt_log[t+8], 8);
        check("ovf_err", err_overflow, 1'b1);
        repeat (12) tick();
        check("ovf_nack", ack_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check_ack($sformatf("ovf%0d", i), i, t+12+i, pat(i), i, 1'b0);
        check("ovf_err_sticky", err_overflow, 1'b1);
        check("ovf_drained", rq_count, 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_err", err_overflow, 1'b0);

        // Full FIFO with a simultaneous pop accepts the request.
        ack_q.delete();
        t = cyc;
        for (int i = 0; i < 8; i++) begin
            set_wr(1'b1, 200, '0);
            set_req(1'b1, i, i, 1'b0);
            tick();
        end
        set_wr(1'b0, 0, '0);
        set_req(1'b1, 5, 9, 1'b1);
        tick();
        set_req(1'b0, 0, 0, 1'b0);
        tick();
        check("fullpop_cnt_before", cnt_log[t+8], 8);
        check("fullpop_cnt_after", cnt_log[t+9], 8);
        check("fullpop_addr", addr_log[t+8], 0);
        check("fullpop_err", err_overflow, 1'b0);
        repeat (12) tick();
        check("fullpop_nack", ack_q.size(), 9);
        for (int i = 0; i < 8; i++)
            check_ack($sformatf("fullpop%0d", i), i, t+10+i, pat(i), i, 1'b0);
        check_ack("fullpop8", 8, t+18, pat(5), 9, 1'b1);

        // Reset with 4 queued and 2 reads in flight.
        t = cyc;
        for (int i = 0; i < 6; i++) begin
            set_wr(1'b1, 200, '0);
            set_req(1'b1, i, i, 1'b1);
            tick();
        end
        set_wr(1'b0, 0, '0);
        set_req(1'b0, 0, 0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        set_wr(1'b1, 201, '0);
        tick();
        rst = 1'b0;
        set_wr(1'b0, 0, '0);
        ack_q.delete();
        check("midrst_cnt_before", cnt_log[t+8], 4);
        check("midrst_cs_in_rst", cs_log[t+8], 1'b0);
        check("midrst_cnt", rq_count, 0);
        repeat (6) tick();
        check("midrst_noack", ack_q.size(), 0);
        ack_q.delete();
        t = cyc;
        set_req(1'b1, 6, 5, 1'b1);
        tick();
        set_req(1'b0, 0, 0, 1'b0);
        repeat (4) tick();
        check("midrst_new_nack", ack_q.size(), 1);
        check_ack("midrst_new", 0, t+3, pat(6), 5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edit_mem_rsp.md
EDIT_MEM_RSP -- requirements
Module: edit_mem_rsp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- ID_NBITS, `PORT_ID_NBITS, port id width
- DATA_NBITS, `DATA_PATH_NBITS (128), chunk data width
- ADDR_NBITS, `ENQ_ED_CMD_PD_BP_NBITS+`PD_CHUNK_DEPTH_NBITS-`DATA_PATH_VB_NBITS, chunk address width
- RQ_DEPTH_NBITS, 3, log2 of the request FIFO depth (8)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- edit_mem_req  in  1  read request, one chunk; no backpressure
- edit_mem_raddr  in  ADDR_NBITS  chunk address
- edit_mem_port_id  in  ID_NBITS  requesting port
- edit_mem_eop  in  1  last chunk of this descriptor
- pd_wr  in  1  descriptor write from the PD writer
- pd_waddr  in  ADDR_NBITS  write address
- pd_wdata  in  DATA_NBITS  write data
- mem_cs  out  1  SRAM select
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_NBITS  SRAM address
- mem_wdata  out  DATA_NBITS  SRAM write data
- mem_rdata  in  DATA_NBITS  SRAM read data, valid 1 cycle after a read select
- edit_mem_ack  out  1  read data valid
- edit_mem_rdata  out  DATA_NBITS  returned chunk
- pd_free_valid  out  1  pulse on the ack of an eop chunk
- pd_free_port_id  out  ID_NBITS  port id of the freed descriptor
- rq_count  out  RQ_DEPTH_NBITS+1  request FIFO occupancy
- err_overflow  out  1  sticky: a request was dropped

Function
REQ-003 Each request (raddr, port_id, eop) SHALL be pushed into an 8-entry request FIFO in the cycle edit_mem_req=1.
REQ-004 SRAM arbitration SHALL be evaluated every cycle; pd_wr has strict priority over reads.
- If pd_wr=1: mem_cs=1, mem_we=1, mem_addr=pd_waddr, mem_wdata=pd_wdata; no pop.
- Else if the FIFO is non-empty: pop the head and drive mem_cs=1, mem_we=0, mem_addr=head raddr.
- Else: mem_cs=0.
REQ-005 The SRAM outputs SHALL be combinational from the FIFO head and the pd_wr inputs. A request pushed in cycle T SHALL be poppable no earlier than T+1.
REQ-006 A popped read SHALL carry {port_id, eop} through a 2-stage valid pipeline. mem_rdata is registered into edit_mem_rdata, and edit_mem_ack=1 SHALL assert 2 cycles after the pop.
REQ-007 Minimum request-to-ack latency SHALL be 3 cycles: request at T, pop at T+1, ack at T+3. Each cycle a write pre-empts a pending read SHALL add 1 cycle.
REQ-008 Acks SHALL be returned strictly in request order, one per accepted request. Back-to-back requests with no writes SHALL produce back-to-back acks.
REQ-009 pd_free_valid SHALL equal edit_mem_ack AND the carried eop. pd_free_port_id SHALL be the carried port_id, registered alongside the ack.
REQ-010 A read SHALL return SRAM contents as of its pop cycle. A write issued in an earlier cycle to the same address is visible to the read; a write issued after the pop is not.
REQ-011 Full FIFO (rq_count=8):
- A request with no pop in the same cycle SHALL be dropped, and err_overflow SHALL set, remaining set until reset.
- A request with a pop in the same cycle SHALL be accepted, and rq_count SHALL stay 8.
REQ-012 rq_count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-013 FIFO read and write pointers SHALL wrap modulo 8 with no bubble.
REQ-014 When the FIFO is empty, pd_wr=0 and no request arrives, mem_cs SHALL be 0, and no ack SHALL be produced 2 cycles later.

Reset
REQ-015 With rst=1 at a rising edge, the following SHALL clear to 0 at that edge: FIFO pointers, rq_count, both pipeline valid bits, edit_mem_ack, pd_free_valid, err_overflow.
REQ-016 edit_mem_rdata and pd_free_port_id SHALL be non-reset data registers.
REQ-017 While rst=1, mem_cs SHALL be 0 regardless of pd_wr and FIFO state.
REQ-018 Reset asserted mid-operation SHALL discard queued and in-flight reads: no ack SHALL appear after reset deasserts for any request accepted before it.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Single read: preload addr 5 = 0xA5..A5; req raddr=5, port 2, eop=1 at T -> mem_cs/we=1/0, addr 5 at T+1; ack, rdata=0xA5..A5, pd_free_valid=1, pd_free_port_id=2 at T+3.
- Streaming: 8 back-to-back reqs, addrs 0-7, no writes -> 8 consecutive acks T+3..T+10 in address order; rq_count never above 1.
- Write priority: reqs at T, T+1 with pd_wr held at T+1..T+3 -> pops at T+4, T+5; acks at T+6, T+7; rq_count peaks at 2.
- Overflow: pd_wr held 10 cycles while 9 reqs arrive -> 9th dropped, err_overflow=1 and sticky; exactly 8 acks after writes stop.
- Full with pop: FIFO full, pd_wr=0, req same cycle -> accepted, rq_count stays 8, err_overflow stays 0.
- Reset mid-flight: 4 reqs queued, 2 in the read pipeline, rst for 1 cycle -> rq_count=0, no acks afterwards; a new req acks 3 cycles later.
